sum_response_checker: RTL and testbench

- Self-checking response monitor for the three-operand constant-offset adder `top`: out1 = in1 + in2 + in3 + 102.
- Consumes the stimulus stream that drives the adder, plus the adder's out1. Aligns both for a configurable DUT latency and computes the expected sum.
- Keeps pass/fail statistics and captures the first mismatch.
- Sits beside the adder in the bench or on-chip BIST wrapper, and replaces ad-hoc per-cycle compare flags.

---
 rtl/sum_response_checker_if.sv | 35 +++
 rtl/sum_response_checker.sv | 140 ++++++++++++++
 tb/tb_sum_response_checker.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sum_response_checker_if.sv
// Bus between the adder stimulus/response stream and sum_response_checker.
// The master side drives stimulus plus the observed DUT result; the slave reports statistics.
interface sum_response_checker_if #(
  parameter int IN_W  = 19,
  parameter int OUT_W = 20,
  parameter int CNT_W = 16
);
  logic             start;
  logic             stim_valid;
  logic             stim_last;
  logic [IN_W-1:0]  in1;
  logic [IN_W-1:0]  in2;
  logic [IN_W-1:0]  in3;
  logic [OUT_W-1:0] out1;
  logic             busy;
  logic             done;
  logic             fail_flag;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [CNT_W-1:0] first_fail_idx;
  logic [OUT_W-1:0] first_fail_exp;
  logic [OUT_W-1:0] first_fail_got;

  modport master (
    output start, stim_valid, stim_last, in1, in2, in3, out1,
    input  busy, done, fail_flag, pass_cnt, fail_cnt,
           first_fail_idx, first_fail_exp, first_fail_got
  );

  modport slave (
    input  start, stim_valid, stim_last, in1, in2, in3, out1,
    output busy, done, fail_flag, pass_cnt, fail_cnt,
           first_fail_idx, first_fail_exp, first_fail_got
  );
endinterface

// File: rtl/sum_response_checker.sv
// Response monitor for out1 = in1 + in2 + in3 + OFFSET with DUT_LAT-cycle alignment.
// Define SUM_CHK_HALT_ON_FAIL_EN to stop the run at the first mismatch.
module sum_response_checker #(
  parameter int IN_W    = 19,
  parameter int OUT_W   = 20,
  parameter int OFFSET  = 102,
  parameter int DUT_LAT = 0,
  parameter int CNT_W   = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  sum_response_checker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int SW = (IN_W + 2 > OUT_W) ? IN_W + 2 : OUT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [SW-1:0]    sum_full;
  logic [OUT_W-1:0] exp_now;
  logic             active, accept, cmp_fire, mismatch, line_quiet;
  logic             cmp_valid;
  logic [OUT_W-1:0] cmp_exp;
  logic [CNT_W-1:0] cmp_idx;
  logic [CNT_W-1:0] idx_cnt, pass_q, fail_q, ff_idx_q;
  logic [OUT_W-1:0] ff_exp_q, ff_got_q;
  logic             flag_q;

  assign sum_full = SW'(bus.in1) + SW'(bus.in2) + SW'(bus.in3) + SW'(OFFSET);
  assign exp_now  = sum_full[OUT_W-1:0];

  // start always wins: it flushes in-flight entries and suppresses this edge's compare
  assign active   = (state == RUN || state == DRAIN) && !bus.start;
  assign accept   = (state == RUN) && bus.stim_valid && !bus.start;
  assign cmp_fire = active && cmp_valid;
  assign mismatch = (cmp_exp != bus.out1);

  if (DUT_LAT == 0) begin : g_nolat
    assign cmp_valid  = accept;
    assign cmp_exp    = exp_now;
    assign cmp_idx    = idx_cnt;
    assign line_quiet = 1'b1;
  end else begin : g_lat
    localparam logic [DUT_LAT-1:0] EARLY_MASK = {DUT_LAT{1'b1}} >> 1;
    logic [DUT_LAT-1:0] pv;
    logic [OUT_W-1:0]   pexp [DUT_LAT];
    logic [CNT_W-1:0]   pidx [DUT_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pv <= '0;
        for (int unsigned k = 0; k < DUT_LAT; k++) begin
          pexp[k] <= '0;
          pidx[k] <= '0;
        end
      end else begin
        pv      <= active ? {pv[DUT_LAT-1:0] << 1} | DUT_LAT'(accept) : '0;
        pexp[0] <= exp_now;
        pidx[0] <= idx_cnt;
        for (int unsigned k = 1; k < DUT_LAT; k++) begin
          pexp[k] <= pexp[k-1];
          pidx[k] <= pidx[k-1];
        end
      end
    end

    assign cmp_valid  = pv[DUT_LAT-1];
    assign cmp_exp    = pexp[DUT_LAT-1];
    assign cmp_idx    = pidx[DUT_LAT-1];
    // the oldest slot is compared on this edge, so only younger slots keep DRAIN alive
    assign line_quiet = ((pv & EARLY_MASK) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (bus.start) state_nxt = RUN;
               else if (accept && bus.stim_last) state_nxt = DRAIN;
      DRAIN:   if (bus.start) state_nxt = RUN;
               else if (line_quiet) state_nxt = DONE;
      DONE:    if (bus.start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
`ifdef SUM_CHK_HALT_ON_FAIL_EN
    if (cmp_fire && mismatch) state_nxt = DONE;
`else
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_cnt  <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      flag_q   <= 1'b0;
      ff_idx_q <= '0;
      ff_exp_q <= '0;
      ff_got_q <= '0;
    end else if (bus.start) begin
      idx_cnt  <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      flag_q   <= 1'b0;
      ff_idx_q <= '0;
      ff_exp_q <= '0;
      ff_got_q <= '0;
    end else begin
      if (accept && idx_cnt != CNT_MAX) idx_cnt <= idx_cnt + 1'b1;
      if (cmp_fire) begin
        if (mismatch) begin
          flag_q <= 1'b1;
          if (fail_q != CNT_MAX) fail_q <= fail_q + 1'b1;
          if (fail_q == '0) begin
            ff_idx_q <= cmp_idx;
            ff_exp_q <= cmp_exp;
            ff_got_q <= bus.out1;
          end
        end else if (pass_q != CNT_MAX) begin
          pass_q <= pass_q + 1'b1;
        end
      end
    end
  end

  assign bus.busy           = (state == RUN) || (state == DRAIN);
  assign bus.done           = (state == DONE);
  assign bus.fail_flag      = flag_q;
  assign bus.pass_cnt       = pass_q;
  assign bus.fail_cnt       = fail_q;
  assign bus.first_fail_idx = ff_idx_q;
  assign bus.first_fail_exp = ff_exp_q;
  assign bus.first_fail_got = ff_got_q;
endmodule

// File: tb/tb_sum_response_checker.sv
// Directed bench for sum_response_checker at DUT_LAT=0 (u0) and DUT_LAT=2 (u2).
// Expectations follow SUM_CHK_HALT_ON_FAIL_EN when the bench is built with it.
module tb_sum_response_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sum_response_checker_if #(.IN_W(19), .OUT_W(20), .CNT_W(16)) b0 ();
  sum_response_checker_if #(.IN_W(19), .OUT_W(20), .CNT_W(16)) b2 ();

  sum_response_checker #(.IN_W(19), .OUT_W(20), .OFFSET(102), .DUT_LAT(0), .CNT_W(16))
    u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  sum_response_checker #(.IN_W(19), .OUT_W(20), .OFFSET(102), .DUT_LAT(2), .CNT_W(16))
    u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

  task automatic clear0();
    b0.start = 1'b0; b0.stim_valid = 1'b0; b0.stim_last = 1'b0;
  endtask

  task automatic clear2();
    b2.start = 1'b0; b2.stim_valid = 1'b0; b2.stim_last = 1'b0;
  endtask

  task automatic vec0(input logic [18:0] a, input logic [18:0] b, input logic [18:0] c,
                      input logic [19:0] o, input logic last);
    b0.stim_valid = 1'b1; b0.stim_last = last;
    b0.in1 = a; b0.in2 = b; b0.in3 = c; b0.out1 = o;
  endtask

  task automatic vec2(input logic valid, input logic last, input logic [19:0] o);
    b2.stim_valid = valid; b2.stim_last = last;
    b2.in1 = 19'd1; b2.in2 = 19'd2; b2.in3 = 19'd3; b2.out1 = o;
  endtask

  // single-vector run on u0; returns at the negedge where done should be visible
  task automatic run0(input logic [18:0] a, input logic [18:0] b, input logic [18:0] c,
                      input logic [19:0] o);
    @(negedge clk); b0.start = 1'b1;
    @(negedge clk); b0.start = 1'b0; vec0(a, b, c, o, 1'b1);
    @(negedge clk); clear0();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++; if ({b0.busy, b0.done, b0.fail_flag} !== 3'b000) begin bad++; $display("FAIL reset_flags0 got=%b exp=000", {b0.busy, b0.done, b0.fail_flag}); end
    total++; if ({b0.pass_cnt, b0.fail_cnt, b0.first_fail_idx} !== 48'd0) begin bad++; $display("FAIL reset_cnt0 got=%0h exp=0", {b0.pass_cnt, b0.fail_cnt, b0.first_fail_idx}); end
    total++; if ({b2.busy, b2.done, b2.first_fail_exp, b2.first_fail_got} !== 42'd0) begin bad++; $display("FAIL reset_u2 got=%0h exp=0", {b2.busy, b2.done, b2.first_fail_exp, b2.first_fail_got}); end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++; if ({b0.busy, b0.done} !== 2'b00) begin bad++; $display("FAIL idle_after_reset got=%b exp=00", {b0.busy, b0.done}); end
  endtask

  task automatic test_single();
    @(negedge clk); b0.start = 1'b1; vec0(19'd9, 19'd9, 19'd9, 20'd0, 1'b1);
    @(negedge clk); b0.start = 1'b0; vec0(19'd1, 19'd2, 19'd3, 20'd108, 1'b1);
    @(negedge clk); clear0();
    total++; if ({b0.busy, b0.done} !== 2'b10) begin bad++; $display("FAIL single_drain got=%b exp=10", {b0.busy, b0.done}); end
    @(negedge clk);
    total++; if ({b0.busy, b0.done} !== 2'b01) begin bad++; $display("FAIL single_done got=%b exp=01", {b0.busy, b0.done}); end
    total++; if (b0.pass_cnt !== 16'd1) begin bad++; $display("FAIL single_pass got=%0d exp=1", b0.pass_cnt); end
    total++; if (b0.fail_cnt !== 16'd0 || b0.fail_flag !== 1'b0) begin bad++; $display("FAIL single_fail got=%0d/%b exp=0/0", b0.fail_cnt, b0.fail_flag); end
    @(negedge clk);
    total++; if (b0.done !== 1'b1) begin bad++; $display("FAIL single_hold got=%b exp=1", b0.done); end
  endtask

  task automatic test_sweep();
    @(negedge clk); b0.start = 1'b1;
    @(negedge clk); b0.start = 1'b0;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 16; c++) begin
          vec0(19'(a), 19'(b), 19'(c), 20'(a + b + c + 102), (a == 15 && b == 15 && c == 15));
          @(negedge clk);
        end
    clear0();
    for (int k = 0; k < 10 && b0.done !== 1'b1; k++) @(negedge clk);
    total++; if (b0.done !== 1'b1) begin bad++; $display("FAIL sweep_timeout got=%b exp=1", b0.done); end
    total++; if (b0.pass_cnt !== 16'd4096) begin bad++; $display("FAIL sweep_pass got=%0d exp=4096", b0.pass_cnt); end
    total++; if (b0.fail_cnt !== 16'd0) begin bad++; $display("FAIL sweep_fail got=%0d exp=0", b0.fail_cnt); end
  endtask

  task automatic test_wrap();
    logic [20:0] wide;
    run0(19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 20'h80063);
    total++; if (b0.pass_cnt !== 16'd1 || b0.fail_cnt !== 16'd0) begin bad++; $display("FAIL wrap_exact got=%0d/%0d exp=1/0", b0.pass_cnt, b0.fail_cnt); end
    wide = 21'h180063;
    run0(19'h7FFFF, 19'h7FFFF, 19'h7FFFF, wide[19:0]);
    total++; if (b0.pass_cnt !== 16'd1 || b0.fail_cnt !== 16'd0) begin bad++; $display("FAIL wrap_trunc got=%0d/%0d exp=1/0", b0.pass_cnt, b0.fail_cnt); end
    run0(19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 20'h80062);
    total++; if (b0.fail_cnt !== 16'd1 || b0.fail_flag !== 1'b1) begin bad++; $display("FAIL wrap_bad_cnt got=%0d/%b exp=1/1", b0.fail_cnt, b0.fail_flag); end
    total++; if (b0.first_fail_exp !== 20'h80063) begin bad++; $display("FAIL wrap_bad_exp got=%0h exp=80063", b0.first_fail_exp); end
    total++; if (b0.first_fail_got !== 20'h80062) begin bad++; $display("FAIL wrap_bad_got got=%0h exp=80062", b0.first_fail_got); end
    total++; if (b0.first_fail_idx !== 16'd0) begin bad++; $display("FAIL wrap_bad_idx got=%0d exp=0", b0.first_fail_idx); end
  endtask

  task automatic test_latency();
    logic early = 1'b0;
    @(negedge clk); b2.start = 1'b1;
    @(negedge clk); b2.start = 1'b0;
    // vector k is compared against out1 two cycles later: vector 5 meets cycle 7
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc == 8) early = b2.done;
      vec2(cyc < 10, cyc == 9, (cyc == 7) ? 20'd0 : 20'd108);
      @(negedge clk);
    end
    clear2();
    for (int k = 0; k < 10 && b2.done !== 1'b1; k++) @(negedge clk);
    total++; if (b2.done !== 1'b1) begin bad++; $display("FAIL lat_timeout got=%b exp=1", b2.done); end
    total++; if (b2.fail_cnt !== 16'd1 || b2.fail_flag !== 1'b1) begin bad++; $display("FAIL lat_fail got=%0d/%b exp=1/1", b2.fail_cnt, b2.fail_flag); end
    total++; if (b2.first_fail_idx !== 16'd5) begin bad++; $display("FAIL lat_idx got=%0d exp=5", b2.first_fail_idx); end
    total++; if (b2.first_fail_exp !== 20'd108 || b2.first_fail_got !== 20'd0) begin bad++; $display("FAIL lat_capture got=%0d/%0d exp=108/0", b2.first_fail_exp, b2.first_fail_got); end
`ifdef SUM_CHK_HALT_ON_FAIL_EN
    total++; if (early !== 1'b1) begin bad++; $display("FAIL lat_early_done got=%b exp=1", early); end
    total++; if (b2.pass_cnt !== 16'd5) begin bad++; $display("FAIL lat_pass got=%0d exp=5", b2.pass_cnt); end
`else
    total++; if (early !== 1'b0) begin bad++; $display("FAIL lat_early_done got=%b exp=0", early); end
    total++; if (b2.pass_cnt !== 16'd9) begin bad++; $display("FAIL lat_pass got=%0d exp=9", b2.pass_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    @(negedge clk); b0.start = 1'b1;
    @(negedge clk); b0.start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      vec0(19'd1, 19'd2, 19'd3, 20'd108, 1'b0);
      @(negedge clk);
    end
    clear0();
    total++; if (b0.pass_cnt !== 16'd7 || b0.busy !== 1'b1) begin bad++; $display("FAIL mid_before got=%0d/%b exp=7/1", b0.pass_cnt, b0.busy); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({b0.busy, b0.done, b0.fail_flag, b0.pass_cnt, b0.fail_cnt} !== 35'd0) begin bad++; $display("FAIL mid_reset got=%0h exp=0", {b0.busy, b0.done, b0.fail_flag, b0.pass_cnt, b0.fail_cnt}); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++; if (b0.done !== 1'b0) begin bad++; $display("FAIL mid_no_done got=%b exp=0", b0.done); end
    b0.start = 1'b1;
    @(negedge clk); b0.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vec0(19'd4, 19'd5, 19'd6, 20'd117, i == 2);
      @(negedge clk);
    end
    clear0();
    for (int k = 0; k < 10 && b0.done !== 1'b1; k++) @(negedge clk);
    total++; if (b0.done !== 1'b1 || b0.pass_cnt !== 16'd3) begin bad++; $display("FAIL mid_rerun got=%b/%0d exp=1/3", b0.done, b0.pass_cnt); end
  endtask

  task automatic test_restart();
    @(negedge clk); b2.start = 1'b1;
    @(negedge clk); b2.start = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      vec2(1'b1, cyc == 2, 20'd108);
      @(negedge clk);
    end
    // in DRAIN now; a bad out1 here must not be counted because start flushes it
    vec2(1'b0, 1'b0, 20'd0); b2.start = 1'b1;
    @(negedge clk); b2.start = 1'b0;
    total++; if ({b2.busy, b2.done} !== 2'b10) begin bad++; $display("FAIL restart_busy got=%b exp=10", {b2.busy, b2.done}); end
    total++; if (b2.pass_cnt !== 16'd0 || b2.fail_cnt !== 16'd0 || b2.fail_flag !== 1'b0) begin bad++; $display("FAIL restart_clear got=%0d/%0d/%b exp=0/0/0", b2.pass_cnt, b2.fail_cnt, b2.fail_flag); end
    vec2(1'b1, 1'b1, 20'd108);
    @(negedge clk); vec2(1'b0, 1'b0, 20'd108);
    @(negedge clk); vec2(1'b0, 1'b0, 20'd0);
    @(negedge clk); vec2(1'b0, 1'b0, 20'd108);
    for (int k = 0; k < 10 && b2.done !== 1'b1; k++) @(negedge clk);
    total++; if (b2.done !== 1'b1) begin bad++; $display("FAIL restart_timeout got=%b exp=1", b2.done); end
    total++; if (b2.fail_cnt !== 16'd1 || b2.pass_cnt !== 16'd0) begin bad++; $display("FAIL restart_cnt got=%0d/%0d exp=1/0", b2.fail_cnt, b2.pass_cnt); end
    total++; if (b2.first_fail_idx !== 16'd0 || b2.first_fail_exp !== 20'd108) begin bad++; $display("FAIL restart_idx got=%0d/%0d exp=0/108", b2.first_fail_idx, b2.first_fail_exp); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear0(); clear2();
    b0.in1 = '0; b0.in2 = '0; b0.in3 = '0; b0.out1 = '0;
    b2.in1 = '0; b2.in2 = '0; b2.in3 = '0; b2.out1 = '0;
    test_reset();
    test_single();
    test_sweep();
    test_wrap();
    test_latency();
    test_reset_mid();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
